// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD converter.
// Widths are fixed here; the converter itself has no parameters.
package bcd_pkg;

    localparam int BIN_W          = 14;
    localparam int BCD_DIGITS     = 4;
    localparam int SCRATCH_DIGITS = BCD_DIGITS + 1;
    localparam int SHIFT_CNT      = 14;
    localparam int CNT_W          = 4;
    localparam int SCRATCH_W      = 4 * SCRATCH_DIGITS;
    localparam int BCD_W          = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [3:0] digit_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  digit_t din,
    output digit_t dout
);

    // Add-3 correction; inputs stay in 0..9 so the sum never exceeds 12.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule : bcd_digit_adj

// File: rtl/bin_to_bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3).
// One conversion takes 14 shift cycles; done pulses 15 cycles after start.
// A fifth scratch digit catches values above 9999 and drives overflow.
//
// Build option: define BIN_TO_BCD_SAT_EN to saturate bcd to 16'h9999 on
// overflow; otherwise bcd reports the low four digits (value mod 10000).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; bin is captured on the accepting edge
// ST_SHIFT | 14 correct-and-shift iterations, busy high
// ST_DONE  | result registered, done high for this single cycle
module bin_to_bcd
    import bcd_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd,
    output logic             overflow
);

    state_t                 state;
    logic [BIN_W-1:0]       sreg;
    logic [SCRATCH_W-1:0]   scratch;
    logic [SCRATCH_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]       cnt;

    logic [SCRATCH_W+BIN_W-1:0] combo_next;
    logic [SCRATCH_W-1:0]       scratch_next;
    logic [BIN_W-1:0]           sreg_next;
    logic                       last_shift;
    logic [BCD_W-1:0]           bcd_next;
    logic                       ovf_next;

    // One correction cell per scratch digit, including the overflow digit.
    for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[4*g +: 4]),
            .dout (scratch_adj[4*g +: 4])
        );
    end

    // Corrected scratch and the binary operand shift together as one word.
    always_comb begin
        combo_next   = {scratch_adj, sreg} << 1;
        scratch_next = combo_next[SCRATCH_W+BIN_W-1 -: SCRATCH_W];
        sreg_next    = combo_next[BIN_W-1:0];
        last_shift   = (cnt == CNT_W'(SHIFT_CNT - 1));
    end

    // Result formatting from the scratch value produced by the final shift.
    always_comb begin
        ovf_next = (scratch_next[SCRATCH_W-1 -: 4] != 4'd0);
`ifdef BIN_TO_BCD_SAT_EN
        if (ovf_next) begin
            bcd_next = {BCD_DIGITS{4'h9}};
        end else begin
            bcd_next = scratch_next[BCD_W-1:0];
        end
`else
        bcd_next = scratch_next[BCD_W-1:0];
`endif
    end

    // Conversion FSM with registered status and result outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            scratch  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg    <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch <= scratch_next;
                    sreg    <= sreg_next;
                    cnt     <= cnt + 1'b1;
                    if (last_shift) begin
                        bcd      <= bcd_next;
                        overflow <= ovf_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : bin_to_bcd

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd: a vector table of conversions plus
// hand-written sequences for ignored start, reset abort and reset priority.
module tb_bin_to_bcd;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    bin_to_bcd dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [13:0] v;
        logic [15:0] eb;
        logic        eo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Start a conversion and watch cycles T+1..T+20.
    task automatic run_conv(input logic [13:0] v, input logic [15:0] eb, input logic eo,
                            input logic [15:0] prev, input string nm);
        int done_at    = -1;
        int done_n     = 0;
        int busy_first = -1;
        int busy_last  = -1;
        @(negedge Clk);
        start = 1'b1;
        bin   = v;
        @(negedge Clk);
        start = 1'b0;
        bin   = ~v;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge Clk);
            if (busy) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k == 7) chk({nm, " bcd held"}, 32'(bcd), 32'(prev));
        end
        chk({nm, " latency"}, 32'(done_at), 32'd15);
        chk({nm, " done count"}, 32'(done_n), 32'd1);
        chk({nm, " busy first"}, 32'(busy_first), 32'd1);
        chk({nm, " busy last"}, 32'(busy_last), 32'd14);
        chk({nm, " bcd"}, 32'(bcd), 32'(eb));
        chk({nm, " overflow"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        logic [15:0] prev;
        int done_n;
        int done_at;

        vecs[0] = '{v: 14'd0,     eb: 16'h0000, eo: 1'b0};
        vecs[1] = '{v: 14'd1234,  eb: 16'h1234, eo: 1'b0};
        vecs[2] = '{v: 14'd9999,  eb: 16'h9999, eo: 1'b0};
`ifdef BIN_TO_BCD_SAT_EN
        vecs[3] = '{v: 14'd16383, eb: 16'h9999, eo: 1'b1};
        vecs[4] = '{v: 14'd10000, eb: 16'h9999, eo: 1'b1};
`else
        vecs[3] = '{v: 14'd16383, eb: 16'h6383, eo: 1'b1};
        vecs[4] = '{v: 14'd10000, eb: 16'h0000, eo: 1'b1};
`endif
        vecs[5] = '{v: 14'd5,     eb: 16'h0005, eo: 1'b0};
        vecs[6] = '{v: 14'd8191,  eb: 16'h8191, eo: 1'b0};
        vecs[7] = '{v: 14'd1,     eb: 16'h0001, eo: 1'b0};

        Reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge Clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bcd", 32'(bcd), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        bin   = 14'd5;
        @(negedge Clk);
        Reset = 1'b0;
        start = 1'b0;
        chk("reset priority busy", 32'(busy), 32'd0);
        done_n = 0;
        repeat (18) begin
            @(negedge Clk);
            if (done || busy) done_n++;
        end
        chk("reset priority activity", 32'(done_n), 32'd0);

        prev = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].v, vecs[i].eb, vecs[i].eo, prev, $sformatf("vec%0d", i));
            prev = vecs[i].eb;
        end

        // Start during SHIFT must be ignored and bin not re-sampled.
        @(negedge Clk);
        start = 1'b1;
        bin   = 14'd42;
        @(negedge Clk);
        start   = 1'b0;
        done_n  = 0;
        done_at = -1;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) @(negedge Clk);
            if (k == 5) begin
                start = 1'b1;
                bin   = 14'd777;
            end
            if (k == 6) start = 1'b0;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
        end
        chk("ignored start latency", 32'(done_at), 32'd15);
        chk("ignored start done count", 32'(done_n), 32'd1);
        chk("ignored start bcd", 32'(bcd), 32'h0042);
        chk("ignored start overflow", 32'(overflow), 32'd0);

        // Reset mid-conversion discards the result.
        @(negedge Clk);
        start = 1'b1;
        bin   = 14'd500;
        @(negedge Clk);
        start  = 1'b0;
        done_n = 0;
        for (int k = 1; k <= 22; k++) begin
            if (k > 1) @(negedge Clk);
            if (k == 6) Reset = 1'b1;
            if (k == 7) Reset = 1'b0;
            if (done) done_n++;
        end
        chk("abort done count", 32'(done_n), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort bcd", 32'(bcd), 32'd0);
        chk("abort overflow", 32'(overflow), 32'd0);

        run_conv(14'd81, 16'h0081, 1'b0, 16'h0000, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bin_to_bcd
